// File: rtl/pic_core_pkg.sv
// Shared constants for the PIC-style core: instruction width, the NOP
// encoding, and a small helper for sizing queue pointers.
package pic_core_pkg;

    localparam int INSTR_W = 12;
    localparam logic [INSTR_W-1:0] NOP_CODE = 12'h000;

    // Width of the post-flush squash down-counter (covers 0..7).
    localparam int SQ_W = 3;

    // Pointer width for a queue of 'depth' entries, never narrower than 1 bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: buffers up to DEPTH fetched words between
// program memory and decode and presents the head word as the current
// instruction. A flush empties the queue, and the next SQUASH words that
// still arrive from memory are stored as NOPs, so fetches issued before the
// branch resolved never reach decode as real instructions.
//
// Handshake: a word transfers from memory when mem_valid and mem_ready are
// both high at a rising edge; mem_ready depends on registered state only.
// Decode consumes the head when issue is high and ir_valid is high at a
// rising edge; issue while empty is ignored. A flush in the same cycle drops
// both transfers.
module instr_prefetch_queue #(
    parameter int IW = pic_core_pkg::INSTR_W,
    parameter int DEPTH = 2,
    parameter int SQUASH = 1,
    parameter logic [IW-1:0] NOP_CODE = pic_core_pkg::NOP_CODE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_valid,
    input  logic [IW-1:0] mem_data,
    output logic          mem_ready,
    input  logic          flush,
    input  logic          issue,
    output logic [IW-1:0] ir_out,
    output logic          ir_valid,
    output logic          squashing
);

    localparam int PW = pic_core_pkg::ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = pic_core_pkg::SQ_W;

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [SW-1:0] SQ_LOAD  = SW'(SQUASH);

    logic [IW-1:0] store [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] sq_cnt;

    logic push;
    logic pop;
    logic sq_active;

    // Handshake qualifiers and outputs, all derived from registered state.
    assign mem_ready = (count < CNT_FULL);
    assign ir_valid  = (count != '0);
    assign sq_active = (sq_cnt != '0);
    assign squashing = sq_active;
    assign push      = mem_valid & mem_ready;
    assign pop       = issue & ir_valid;
    assign ir_out    = ir_valid ? store[rd_ptr] : NOP_CODE;

    // Storage write: squashed fetches land as NOPs; nothing is written on flush.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            store[wr_ptr] <= sq_active ? NOP_CODE : mem_data;
        end
    end

    // Pointer, occupancy and squash-counter state; reset beats flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            sq_cnt <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            sq_cnt <= SQ_LOAD;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
                if (sq_active) begin
                    sq_cnt <= sq_cnt - 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: instance 0 has DEPTH=2, instance 1 has
// DEPTH=3, both with SQUASH=1. Only one instance is driven at a time; a
// single expected queue models the active one.
module tb_instr_prefetch_queue;

  localparam int IW = 12;
  localparam logic [IW-1:0] NOP = 12'h000;
  localparam int SQ = 1;

  logic          clk;
  logic          rst;
  logic          mem_valid [2];
  logic [IW-1:0] mem_data  [2];
  logic          mem_ready [2];
  logic          flush     [2];
  logic          issue     [2];
  logic [IW-1:0] ir_out    [2];
  logic          ir_valid  [2];
  logic          squashing [2];

  int n_checks;
  int n_errs;
  logic [IW-1:0] exp_q[$];
  int m_sq;
  int b_pushes;

  instr_prefetch_queue #(.IW(IW), .DEPTH(2), .SQUASH(SQ), .NOP_CODE(NOP)) u_a (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid[0]), .mem_data(mem_data[0]), .mem_ready(mem_ready[0]),
    .flush(flush[0]), .issue(issue[0]),
    .ir_out(ir_out[0]), .ir_valid(ir_valid[0]), .squashing(squashing[0])
  );

  instr_prefetch_queue #(.IW(IW), .DEPTH(3), .SQUASH(SQ), .NOP_CODE(NOP)) u_b (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid[1]), .mem_data(mem_data[1]), .mem_ready(mem_ready[1]),
    .flush(flush[1]), .issue(issue[1]),
    .ir_out(ir_out[1]), .ir_valid(ir_valid[1]), .squashing(squashing[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      mem_valid[i] = 1'b0;
      mem_data[i]  = '0;
      flush[i]     = 1'b0;
      issue[i]     = 1'b0;
    end
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_sq = 0;
    b_pushes = 0;
  endtask

  // Driver: one cycle on instance idx. Called 1 time unit after a rising edge;
  // returns 1 time unit after the next one. Scoreboard pops are compared
  // against ir_out before the consuming edge.
  task automatic drive(input int idx, input logic v, input logic [IW-1:0] d,
                       input logic iss, input logic fl);
    int dep;
    logic acc;
    logic popd;
    logic [IW-1:0] head;
    dep = (idx == 0) ? 2 : 3;
    mem_valid[idx] = v;
    mem_data[idx]  = d;
    issue[idx]     = iss;
    flush[idx]     = fl;
    if (!fl && iss && exp_q.size() > 0) begin
      head = exp_q[0];
      n_checks++;
      if (ir_out[idx] !== head) begin
        n_errs++;
        $display("FAIL sb_pop[%0d] ir_out=%h expected=%h t=%0t", idx, ir_out[idx], head, $time);
      end
    end
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      m_sq = SQ;
    end else begin
      popd = iss && (exp_q.size() > 0);
      acc  = v && (exp_q.size() < dep);
      if (popd) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back((m_sq != 0) ? NOP : d);
        if (m_sq != 0) m_sq--;
        if (idx == 1) b_pushes++;
      end
    end
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    apply_reset(2);
    n_checks++;
    if (ir_valid[0] !== 1'b0) begin n_errs++; $display("FAIL reset_ir_valid got=%b exp=0", ir_valid[0]); end
    n_checks++;
    if (ir_out[0] !== 12'h000) begin n_errs++; $display("FAIL reset_ir_out got=%h exp=000", ir_out[0]); end
    n_checks++;
    if (mem_ready[0] !== 1'b1) begin n_errs++; $display("FAIL reset_mem_ready got=%b exp=1", mem_ready[0]); end
    n_checks++;
    if (squashing[0] !== 1'b0) begin n_errs++; $display("FAIL reset_squashing got=%b exp=0", squashing[0]); end
  endtask

  task automatic test_fill();
    drive(0, 1'b1, 12'hA01, 1'b0, 1'b0);
    drive(0, 1'b1, 12'hA02, 1'b0, 1'b0);
    n_checks++;
    if (u_a.count !== 2'd2) begin n_errs++; $display("FAIL fill_count got=%0d exp=2", u_a.count); end
    n_checks++;
    if (mem_ready[0] !== 1'b0) begin n_errs++; $display("FAIL fill_mem_ready got=%b exp=0", mem_ready[0]); end
    drive(0, 1'b1, 12'hA03, 1'b0, 1'b0);
    n_checks++;
    if (u_a.count !== 2'd2) begin n_errs++; $display("FAIL full_reject_count got=%0d exp=2", u_a.count); end
    n_checks++;
    if (ir_out[0] !== 12'hA01) begin n_errs++; $display("FAIL fill_head got=%h exp=a01", ir_out[0]); end
    n_checks++;
    if (exp_q.size() != 2) begin n_errs++; $display("FAIL fill_model_size got=%0d exp=2", exp_q.size()); end
  endtask

  task automatic test_simul_push_pop();
    drive(0, 1'b0, '0, 1'b1, 1'b0);
    drive(0, 1'b1, 12'hA03, 1'b1, 1'b0);
    n_checks++;
    if (u_a.count !== 2'd1) begin n_errs++; $display("FAIL simul_count got=%0d exp=1", u_a.count); end
    n_checks++;
    if (ir_out[0] !== 12'hA03) begin n_errs++; $display("FAIL simul_head got=%h exp=a03", ir_out[0]); end
    drive(0, 1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (ir_valid[0] !== 1'b0) begin n_errs++; $display("FAIL drain_ir_valid got=%b exp=0", ir_valid[0]); end
    drive(0, 1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (ir_out[0] !== NOP) begin n_errs++; $display("FAIL empty_issue_ir_out got=%h exp=000", ir_out[0]); end
  endtask

  task automatic test_flush_squash();
    drive(0, 1'b1, 12'hB01, 1'b0, 1'b0);
    drive(0, 1'b1, 12'hB02, 1'b0, 1'b0);
    drive(0, 1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if (ir_valid[0] !== 1'b0) begin n_errs++; $display("FAIL flush_ir_valid got=%b exp=0", ir_valid[0]); end
    n_checks++;
    if (squashing[0] !== 1'b1) begin n_errs++; $display("FAIL flush_squashing got=%b exp=1", squashing[0]); end
    n_checks++;
    if (mem_ready[0] !== 1'b1) begin n_errs++; $display("FAIL flush_mem_ready got=%b exp=1", mem_ready[0]); end
    drive(0, 1'b1, 12'hB05, 1'b0, 1'b0);
    n_checks++;
    if (squashing[0] !== 1'b0) begin n_errs++; $display("FAIL squash_drop got=%b exp=0", squashing[0]); end
    n_checks++;
    if (ir_out[0] !== NOP) begin n_errs++; $display("FAIL squash_nop got=%h exp=000", ir_out[0]); end
    drive(0, 1'b1, 12'hB06, 1'b0, 1'b0);
    drive(0, 1'b0, '0, 1'b1, 1'b0);
    drive(0, 1'b0, '0, 1'b1, 1'b0);
    // Back-to-back flushes reload the counter rather than accumulate.
    drive(0, 1'b0, '0, 1'b0, 1'b1);
    drive(0, 1'b0, '0, 1'b0, 1'b1);
    drive(0, 1'b1, 12'hD01, 1'b0, 1'b0);
    drive(0, 1'b1, 12'hD02, 1'b0, 1'b0);
    drive(0, 1'b0, '0, 1'b1, 1'b0);
    drive(0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_flush_collision();
    drive(0, 1'b1, 12'hC01, 1'b0, 1'b0);
    drive(0, 1'b1, 12'hC02, 1'b1, 1'b1);
    n_checks++;
    if (ir_valid[0] !== 1'b0) begin n_errs++; $display("FAIL coll_ir_valid got=%b exp=0", ir_valid[0]); end
    n_checks++;
    if (u_a.count !== 2'd0) begin n_errs++; $display("FAIL coll_count got=%0d exp=0", u_a.count); end
    n_checks++;
    if (u_a.sq_cnt !== 3'(SQ)) begin n_errs++; $display("FAIL coll_sq_cnt got=%0d exp=%0d", u_a.sq_cnt, SQ); end
    drive(0, 1'b1, 12'hC03, 1'b0, 1'b0);
    drive(0, 1'b1, 12'hC04, 1'b0, 1'b0);
    drive(0, 1'b0, '0, 1'b1, 1'b0);
    drive(0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    logic [IW-1:0] d;
    logic [1:0] exp_wr;
    apply_reset(1);
    drive(1, 1'b1, 12'h301, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      d = IW'($urandom_range(1, 4095));
      drive(1, 1'b1, d, 1'b1, 1'b0);
      exp_wr = 2'(b_pushes % 3);
      n_checks++;
      if (u_b.wr_ptr !== exp_wr) begin n_errs++; $display("FAIL wrap_wr_ptr[%0d] got=%0d exp=%0d", i, u_b.wr_ptr, exp_wr); end
    end
    drive(1, 1'b0, '0, 1'b1, 1'b0);
    drive(1, 1'b1, 12'h3AA, 1'b0, 1'b0);
    drive(1, 1'b1, 12'h3BB, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1, 1'b1, 12'h3CC, 1'b1, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    m_sq = 0;
    n_checks++;
    if (ir_valid[1] !== 1'b0) begin n_errs++; $display("FAIL midrst_ir_valid got=%b exp=0", ir_valid[1]); end
    n_checks++;
    if (mem_ready[1] !== 1'b1) begin n_errs++; $display("FAIL midrst_mem_ready got=%b exp=1", mem_ready[1]); end
  endtask

  task automatic test_random();
    logic v;
    logic iss;
    logic fl;
    apply_reset(1);
    for (int i = 0; i < 80; i++) begin
      v   = 1'($urandom_range(0, 1));
      iss = 1'($urandom_range(0, 1));
      fl  = ($urandom_range(0, 11) == 0);
      drive(1, v, IW'($urandom_range(1, 4095)), iss, fl);
      n_checks++;
      if (ir_valid[1] !== (exp_q.size() > 0)) begin n_errs++; $display("FAIL rand_ir_valid[%0d] got=%b exp=%b", i, ir_valid[1], exp_q.size() > 0); end
      n_checks++;
      if (mem_ready[1] !== (exp_q.size() < 3)) begin n_errs++; $display("FAIL rand_mem_ready[%0d] got=%b exp=%b", i, mem_ready[1], exp_q.size() < 3); end
      n_checks++;
      if (squashing[1] !== (m_sq != 0)) begin n_errs++; $display("FAIL rand_squashing[%0d] got=%b exp=%b", i, squashing[1], m_sq != 0); end
    end
    while (exp_q.size() > 0) drive(1, 1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errs = 0;
    m_sq = 0;
    b_pushes = 0;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_simul_push_pop();
    test_flush_squash();
    test_flush_collision();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
